// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multi-cycle controller
//   state_e    : controller sequencing states
//   op_class_e : opcode classes produced by opcode_class_decoder
//   OPC_*      : opcode class field patterns, OP_HALT full HALT opcode
//   ALU_ADD    : ALU operation used for LOAD/STORE address generation
//   cj_taken() : conditional jump resolution from opcode bit 2 and zero flag
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_LD  = 3'd2,
    CLS_ST  = 3'd3,
    CLS_CJ  = 3'd4,
    CLS_J   = 3'd5,
    CLS_HLT = 3'd6,
    CLS_ILL = 3'd7
  } op_class_e;

  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [1:0] OPC_R   = 2'b00;    // instruction[5:4]
  localparam logic [1:0] OPC_I   = 2'b01;    // instruction[5:4]
  localparam logic [3:0] OPC_LD  = 4'b1000;  // instruction[5:2]
  localparam logic [3:0] OPC_ST  = 4'b1001;  // instruction[5:2]
  localparam logic [2:0] OPC_CJ  = 3'b110;   // instruction[5:3]
  localparam logic [3:0] OPC_J   = 4'b1110;  // instruction[5:2]

  localparam logic [2:0] ALU_ADD = 3'b000;

  // instruction[2] selects the polarity: 0 = jump on zero, 1 = jump on not-zero.
  function automatic logic cj_taken(input logic [5:0] instr, input logic zero_flag);
    return instr[2] ? ~zero_flag : zero_flag;
  endfunction

endpackage

// File: rtl/opcode_class_decoder.sv
// rtl/opcode_class_decoder.sv - priority decode of the opcode field into an op class
//   instr_i [5:0] : opcode field of the instruction register
//   class_o       : op_class_e, first matching class in priority order, CLS_ILL otherwise
module opcode_class_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0] instr_i,
  output op_class_e  class_o
);

  // HALT must be tested first: its pattern would otherwise fall into no other
  // class, but keeping the priority explicit protects against future overlaps.
  always_comb begin
    class_o = CLS_ILL;
    if (instr_i == OP_HALT) begin
      class_o = CLS_HLT;
    end else if (instr_i[5:4] == OPC_R) begin
      class_o = CLS_R;
    end else if (instr_i[5:4] == OPC_I) begin
      class_o = CLS_I;
    end else if (instr_i[5:2] == OPC_LD) begin
      class_o = CLS_LD;
    end else if (instr_i[5:2] == OPC_ST) begin
      class_o = CLS_ST;
    end else if (instr_i[5:3] == OPC_CJ) begin
      class_o = CLS_CJ;
    end else if (instr_i[5:2] == OPC_J) begin
      class_o = CLS_J;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle sequencing FSM for the processor datapath
//   clk, rst (sync, active-high)    : clock and reset
//   instruction[5:0], zero          : opcode from IR, registered ALU zero flag
//   mem_ready                       : memory completes current access this cycle
//   mem_read, mem_write, sel_IorD   : shared memory port strobes and address select
//   ir_load, pc_load                : IR and PC load enables
//   sel_PCSrc_plus1/offset/const    : one-hot PC source, only with pc_load
//   ALU_op[2:0], sel_ALUScr_reg/const : ALU operation and B-operand select
//   reg_write, sel_WB_mem           : register file write enable and write-back source
//   halted                          : stopped on HALT
//   cycle_count, instr_count [31:0] : performance counters, present only with CTRL_PERF_CNT_EN
module multicycle_controller
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] instruction,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       sel_IorD,
  output logic       ir_load,
  output logic       pc_load,
  output logic       sel_PCSrc_plus1,
  output logic       sel_PCSrc_offset,
  output logic       sel_PCSrc_const,
  output logic [2:0] ALU_op,
  output logic       sel_ALUScr_reg,
  output logic       sel_ALUScr_const,
  output logic       reg_write,
  output logic       sel_WB_mem,
  output logic       halted
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
`endif
);

  state_e    state_q;
  state_e    state_d;
  op_class_e op_class;

  opcode_class_decoder u_opcode_class_decoder (
    .instr_i (instruction),
    .class_o (op_class)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are decoded from the current state and opcode; ir_load and the
  // STORE completion pc_load additionally depend on mem_ready. Everything is
  // held at 0 while rst is high so an abandoned access leaves no side effects.
  always_comb begin
    state_d          = state_q;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    sel_IorD         = 1'b0;
    ir_load          = 1'b0;
    pc_load          = 1'b0;
    sel_PCSrc_plus1  = 1'b0;
    sel_PCSrc_offset = 1'b0;
    sel_PCSrc_const  = 1'b0;
    ALU_op           = 3'b000;
    sel_ALUScr_reg   = 1'b0;
    sel_ALUScr_const = 1'b0;
    reg_write        = 1'b0;
    sel_WB_mem       = 1'b0;
    halted           = 1'b0;

    if (rst) begin
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_load = 1'b1;
            state_d = DECODE;
          end
        end

        DECODE: begin
          case (op_class)
            CLS_R, CLS_I, CLS_LD, CLS_ST: begin
              state_d = EXEC;
            end
            CLS_CJ: begin
              pc_load = 1'b1;
              if (cj_taken(instruction, zero)) begin
                sel_PCSrc_offset = 1'b1;
              end else begin
                sel_PCSrc_plus1 = 1'b1;
              end
              state_d = FETCH;
            end
            CLS_J: begin
              pc_load         = 1'b1;
              sel_PCSrc_const = 1'b1;
              state_d         = FETCH;
            end
            CLS_HLT: begin
              state_d = HALT;
            end
            default: begin
              // Illegal opcodes retire as a NOP.
              pc_load         = 1'b1;
              sel_PCSrc_plus1 = 1'b1;
              state_d         = FETCH;
            end
          endcase
        end

        EXEC: begin
          // instruction[3] is reserved; only [2:0] select the ALU operation.
          if (op_class == CLS_R || op_class == CLS_I) begin
            ALU_op = instruction[2:0];
          end else begin
            ALU_op = ALU_ADD;
          end
          if (op_class == CLS_R) begin
            sel_ALUScr_reg = 1'b1;
          end else begin
            sel_ALUScr_const = 1'b1;
          end
          if (op_class == CLS_LD || op_class == CLS_ST) begin
            state_d = MEM;
          end else begin
            state_d = WB;
          end
        end

        MEM: begin
          sel_IorD = 1'b1;
          if (op_class == CLS_LD) begin
            mem_read = 1'b1;
          end else begin
            mem_write = 1'b1;
          end
          if (mem_ready) begin
            if (op_class == CLS_LD) begin
              state_d = WB;
            end else begin
              // STORE has no write-back, so it retires here.
              pc_load         = 1'b1;
              sel_PCSrc_plus1 = 1'b1;
              state_d         = FETCH;
            end
          end
        end

        WB: begin
          reg_write       = 1'b1;
          sel_WB_mem      = (op_class == CLS_LD);
          pc_load         = 1'b1;
          sel_PCSrc_plus1 = 1'b1;
          state_d         = FETCH;
        end

        HALT: begin
          halted = 1'b1;
        end

        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] instr_cnt_q;

  // Both counters wrap naturally at 2^32 and stop advancing once halted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= 32'd0;
      instr_cnt_q <= 32'd0;
    end else if (state_q != HALT) begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (pc_load) begin
        instr_cnt_q <= instr_cnt_q + 32'd1;
      end
    end
  end

  assign cycle_count = cycle_cnt_q;
  assign instr_count = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] instruction;
  logic       zero;
  logic       mem_ready;
  logic       mem_read, mem_write, sel_IorD, ir_load, pc_load;
  logic       sel_PCSrc_plus1, sel_PCSrc_offset, sel_PCSrc_const;
  logic [2:0] ALU_op;
  logic       sel_ALUScr_reg, sel_ALUScr_const, reg_write, sel_WB_mem, halted;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_count, instr_count;
`endif

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk              (clk),
    .rst              (rst),
    .instruction      (instruction),
    .zero             (zero),
    .mem_ready        (mem_ready),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .sel_IorD         (sel_IorD),
    .ir_load          (ir_load),
    .pc_load          (pc_load),
    .sel_PCSrc_plus1  (sel_PCSrc_plus1),
    .sel_PCSrc_offset (sel_PCSrc_offset),
    .sel_PCSrc_const  (sel_PCSrc_const),
    .ALU_op           (ALU_op),
    .sel_ALUScr_reg   (sel_ALUScr_reg),
    .sel_ALUScr_const (sel_ALUScr_const),
    .reg_write        (reg_write),
    .sel_WB_mem       (sel_WB_mem),
    .halted           (halted)
`ifdef CTRL_PERF_CNT_EN
    ,
    .cycle_count      (cycle_count),
    .instr_count      (instr_count)
`endif
  );

  // Output vector: {mem_read, mem_write, sel_IorD, ir_load, pc_load, plus1,
  // offset, const, ALU_op[2:0], alu_reg, alu_const, reg_write, wb_mem, halted}
  localparam logic [15:0] V_MR    = 16'h8000;
  localparam logic [15:0] V_MW    = 16'h4000;
  localparam logic [15:0] V_IORD  = 16'h2000;
  localparam logic [15:0] V_IR    = 16'h1000;
  localparam logic [15:0] V_PC    = 16'h0800;
  localparam logic [15:0] V_P1    = 16'h0400;
  localparam logic [15:0] V_OFF   = 16'h0200;
  localparam logic [15:0] V_CONST = 16'h0100;
  localparam logic [15:0] V_AREG  = 16'h0010;
  localparam logic [15:0] V_ACST  = 16'h0008;
  localparam logic [15:0] V_RW    = 16'h0004;
  localparam logic [15:0] V_WBM   = 16'h0002;
  localparam logic [15:0] V_HLT   = 16'h0001;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_CJ = 4, K_J = 5, K_HLT = 6, K_ILL = 7;

  wire [15:0] dut_vec = {mem_read, mem_write, sel_IorD, ir_load, pc_load,
                         sel_PCSrc_plus1, sel_PCSrc_offset, sel_PCSrc_const,
                         ALU_op, sel_ALUScr_reg, sel_ALUScr_const,
                         reg_write, sel_WB_mem, halted};

  typedef struct packed {
    logic        rst;
    logic        mem_ready;
    logic        zero;
    logic [5:0]  instr;
    logic [15:0] exp;
  } step_t;

  step_t sb_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int cls_of(input logic [5:0] op);
    if (op == 6'b111111)      return K_HLT;
    if (op[5:4] == 2'b00)     return K_R;
    if (op[5:4] == 2'b01)     return K_I;
    if (op[5:2] == 4'b1000)   return K_LD;
    if (op[5:2] == 4'b1001)   return K_ST;
    if (op[5:3] == 3'b110)    return K_CJ;
    if (op[5:2] == 4'b1110)   return K_J;
    return K_ILL;
  endfunction

  task automatic push(input logic r, input logic mr, input logic z,
                      input logic [5:0] op, input logic [15:0] e);
    step_t s;
    s.rst = r; s.mem_ready = mr; s.zero = z; s.instr = op; s.exp = e;
    sb_q.push_back(s);
  endtask

  // Expected per-cycle outputs for one instruction. mem_ready is randomised in
  // cycles where it must be ignored. abort_mem replaces MEM completion by a reset.
  task automatic issue(input logic [5:0] op, input logic z, input int f_stall,
                       input int m_stall, input bit abort_mem);
    int          c;
    logic        taken;
    logic [2:0]  alu;
    logic [15:0] e;
    c = cls_of(op);
    for (int i = 0; i < f_stall; i++) push(1'b0, 1'b0, z, op, V_MR);
    push(1'b0, 1'b1, z, op, V_MR | V_IR);
    case (c)
      K_CJ: begin
        taken = op[2] ? !z : z;
        push(1'b0, 1'($urandom_range(0, 1)), z, op, V_PC | (taken ? V_OFF : V_P1));
      end
      K_J:   push(1'b0, 1'($urandom_range(0, 1)), z, op, V_PC | V_CONST);
      K_ILL: push(1'b0, 1'($urandom_range(0, 1)), z, op, V_PC | V_P1);
      K_HLT: begin
        push(1'b0, 1'($urandom_range(0, 1)), z, op, 16'h0000);
        for (int i = 0; i < 5; i++) push(1'b0, 1'($urandom_range(0, 1)), z, op, V_HLT);
      end
      default: begin
        push(1'b0, 1'($urandom_range(0, 1)), z, op, 16'h0000);
        alu = (c == K_R || c == K_I) ? op[2:0] : 3'b000;
        push(1'b0, 1'($urandom_range(0, 1)), z, op,
             {8'h00, alu, 5'b00000} | ((c == K_R) ? V_AREG : V_ACST));
        if (c == K_LD || c == K_ST) begin
          e = V_IORD | ((c == K_LD) ? V_MR : V_MW);
          for (int i = 0; i < m_stall; i++) push(1'b0, 1'b0, z, op, e);
          if (abort_mem) begin
            push(1'b1, 1'b0, z, op, 16'h0000);
            return;
          end
          push(1'b0, 1'b1, z, op, e | ((c == K_ST) ? (V_PC | V_P1) : 16'h0000));
        end
        if (c != K_ST) begin
          push(1'b0, 1'($urandom_range(0, 1)), z, op,
               V_RW | V_PC | V_P1 | ((c == K_LD) ? V_WBM : 16'h0000));
        end
      end
    endcase
  endtask

  task automatic drain();
    step_t s;
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      rst = s.rst; mem_ready = s.mem_ready; zero = s.zero; instruction = s.instr;
      @(negedge clk);
      check($sformatf("cyc%0d op%b rst%0d", cyc, s.instr, s.rst), {16'h0, dut_vec}, {16'h0, s.exp});
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; instruction = 6'b000000;
    @(posedge clk);
    #1;
    push(1'b1, 1'b1, 1'b0, 6'b000000, 16'h0000);
    push(1'b1, 1'b0, 1'b0, 6'b000000, 16'h0000);
    drain();

    issue(6'b000010, 1'b0, 0, 0, 1'b0);  // R-type, ALU 010
    issue(6'b010101, 1'b0, 2, 0, 1'b0);  // I-type with fetch stalls
    issue(6'b001111, 1'b0, 0, 0, 1'b0);  // R-type, reserved bit 3 set
    issue(6'b100000, 1'b0, 0, 3, 1'b0);  // LOAD with 3 MEM stalls
    issue(6'b100100, 1'b0, 1, 1, 1'b0);  // STORE with stalls
    issue(6'b100011, 1'b0, 0, 0, 1'b0);  // LOAD no stalls
    issue(6'b100111, 1'b0, 0, 0, 1'b0);  // STORE no stalls
    issue(6'b110000, 1'b1, 0, 0, 1'b0);  // CJ taken on zero
    issue(6'b110000, 1'b0, 0, 0, 1'b0);  // CJ not taken
    issue(6'b110100, 1'b1, 0, 0, 1'b0);  // CJ on not-zero, not taken
    issue(6'b110100, 1'b0, 1, 0, 1'b0);  // CJ on not-zero, taken
    issue(6'b111011, 1'b0, 0, 0, 1'b0);  // unconditional jump
    issue(6'b101000, 1'b0, 0, 0, 1'b0);  // illegal
    issue(6'b111100, 1'b0, 0, 0, 1'b0);  // illegal, just below HALT
    issue(6'b100101, 1'b0, 0, 2, 1'b1);  // STORE aborted by reset in MEM
    drain();

`ifdef CTRL_PERF_CNT_EN
    check("cycle_count_after_rst", cycle_count, 32'd0);
    check("instr_count_after_rst", instr_count, 32'd0);
`endif

    issue(6'b000001, 1'b0, 0, 0, 1'b0);
    drain();

`ifdef CTRL_PERF_CNT_EN
    check("cycle_count_one_r", cycle_count, 32'd4);
    check("instr_count_one_r", instr_count, 32'd1);
`endif

    issue(6'b111111, 1'b0, 0, 0, 1'b0);  // HALT, then held halted
    push(1'b1, 1'b1, 1'b0, 6'b111111, 16'h0000);
    issue(6'b011010, 1'b0, 0, 0, 1'b0);  // restart after reset
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the multi-cycle version of the processor datapath. Drives the ALU, register file, PC and the single shared instruction/data memory port over several cycles per instruction, in place of the one-cycle combinational control decode. Stalls on the memory ready handshake. Sits between the instruction register (opcode input) and every datapath select/enable.

## Interface
- No parameters; all encodings come from the shared package.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset; synchronous, active-high.
- instruction  in  6  opcode field of the instruction register.
- zero  in  1  registered ALU zero flag from the previous ALU operation.
- mem_ready  in  1  memory completes the current read or write this cycle.
- mem_read / mem_write  out  1  memory strobes, held until mem_ready.
- sel_IorD  out  1  memory address select: 0 = PC, 1 = ALU result.
- ir_load  out  1  instruction register load enable.
- pc_load  out  1  PC load enable.
- sel_PCSrc_plus1 / sel_PCSrc_offset / sel_PCSrc_const  out  1  one-hot PC source; valid only when pc_load=1, otherwise all 0.
- ALU_op  out  3  ALU operation.
- sel_ALUScr_reg / sel_ALUScr_const  out  1  ALU B-operand select, one-hot in EXEC, else 0.
- reg_write  out  1  register file write enable.
- sel_WB_mem  out  1  write-back source: 1 = memory data, 0 = ALU result.
- halted  out  1  controller stopped on HALT.

## Operation
- Opcode classes, in priority order:
  - HALT 6'b111111
  - R-type [5:4]=2'b00
  - I-type [5:4]=2'b01
  - LOAD [5:2]=4'b1000
  - STORE [5:2]=4'b1001
  - conditional jump [5:3]=3'b110
  - unconditional jump [5:2]=4'b1110
  - everything else illegal, executed as NOP.
- ALU_op = instruction[2:0] for R/I-type. instruction[3] is reserved and ignored. LOAD/STORE force ALU_op = ALU_ADD (3'b000).
- States:
  - FETCH: mem_read=1, sel_IorD=0. When mem_ready: ir_load=1, go to DECODE. Otherwise stay.
  - DECODE: R/I/LOAD/STORE go to EXEC.
    - Conditional jump: pc_load=1. Source is offset if taken, else plus1. Taken = zero when instruction[2]=0; taken = !zero when instruction[2]=1. Go to FETCH.
    - Unconditional jump: pc_load=1, sel_PCSrc_const=1, go to FETCH.
    - Illegal: pc_load=1, plus1, go to FETCH.
    - HALT: go to HALT.
  - EXEC: drive ALU_op and ALU source (reg for R-type, const for I/LOAD/STORE). R/I go to WB; LOAD/STORE go to MEM.
  - MEM: sel_IorD=1, mem_read (LOAD) or mem_write (STORE), held until mem_ready.
    - On mem_ready, LOAD goes to WB.
    - On mem_ready, STORE asserts pc_load with plus1 and goes to FETCH.
  - WB: reg_write=1, sel_WB_mem=1 for LOAD, pc_load=1, plus1, go to FETCH.
  - HALT: halted=1, all other outputs 0. Only rst leaves this state.
- ir_load and the MEM-state pc_load are Mealy outputs (gated by mem_ready). All others are decoded from state and opcode.
- Reset: while rst=1 every output is forced to 0, including halted. The state register loads FETCH. The first fetch strobe appears in the cycle after rst deasserts. Reset mid-transaction abandons the access with no pc_load or reg_write.

## Timing
- Latencies, with mem_ready tied high:
  - jumps and NOP: 2 cycles
  - R/I-type: 4 cycles
  - STORE: 4 cycles
  - LOAD: 5 cycles
- Each cycle of mem_ready=0 adds exactly one cycle, in FETCH or MEM.
- pc_load fires exactly once per instruction, in its final cycle. HALT never fires it.
- instruction must stay stable from DECODE until the instruction's final cycle (IR is loaded only in FETCH).
- mem_ready outside FETCH/MEM is ignored.

## Configuration
- CTRL_PERF_CNT_EN defined adds two outputs, both cleared by rst, wrapping modulo 2^32, frozen in HALT:
  - cycle_count[31:0]: increments every non-reset cycle.
  - instr_count[31:0]: increments on every pc_load.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

## Structure
- Package ctrl_pkg holds:
  - state enum (FETCH, DECODE, EXEC, MEM, WB, HALT)
  - opcode class constants and the HALT opcode
  - ALU_ADD
  - class enum (R, I, LD, ST, CJ, J, HLT, ILL)
- Sub-module opcode_class_decoder: combinational, maps instruction[5:0] to the class enum with the priority above. Shared with the assembler-side checker.

## Test plan
- R-type 6'b000010 with mem_ready=1 → ir_load cycle 1; EXEC cycle 3 with ALU_op=3'b010, sel_ALUScr_reg=1; WB cycle 4 with reg_write=1, pc_load, plus1.
- LOAD 6'b100000, mem_ready low 3 cycles in MEM → mem_read and sel_IorD held 4 cycles; then WB with sel_WB_mem=1; total 8 cycles.
- Conditional jump 6'b110000 with zero=1 → DECODE pc_load with offset. Same opcode with zero=0 → plus1. 6'b110100 with zero=1 → plus1.
- 6'b111011 → pc_load with const in DECODE. Illegal 6'b101000 → plus1 in DECODE, no reg_write or mem strobe.
- HALT 6'b111111 → halted=1 permanently, no pc_load. rst for 1 cycle → all outputs 0 that cycle; FETCH mem_read=1 the next cycle.
- rst asserted in MEM of a STORE with mem_ready=0 → no pc_load, mem_write=0 that cycle, restart in FETCH. With CTRL_PERF_CNT_EN, both counters read 0 after rst.
